// File: rtl/dm_multicycle.sv
// dm_multicycle: MIPS data memory with valid/ready request, configurable latency, and byte/half/word access.
module dm_multicycle #(
    parameter int DEPTH_WORDS = 3072,
    parameter int LATENCY     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    state_t state, next;
    logic [7:0]  cnt;
    logic        we_q;
    logic [2:0]  op_q;
    logic [31:0] addr_q, wdata_q, pc_q;
    logic [31:0] mem [DEPTH_WORDS];
    logic        is_half, is_byte, err;
    logic [31:0] old, load, aligned, mask, merged;
    logic [15:0] half_v;
    logic [7:0]  byte_v;
    logic [3:0]  lanes;
    always_ff @(posedge clk) state <= reset ? IDLE : next;
    always_comb begin
        next = state;
        case (state)
            IDLE: next = req_valid ? BUSY : IDLE;
            BUSY: next = cnt == 8'd0 ? RESP : BUSY;
            default: next = IDLE;
        endcase
    end
    assign req_ready  = state == IDLE;
    assign resp_valid = state == RESP;
    // Lane selection and load extension for the latched request
    always_comb begin
        is_half = op_q == 3'd1 || op_q == 3'd2;
        is_byte = op_q == 3'd3 || op_q == 3'd4;
        err     = op_q > 3'd4 || (op_q == 3'd0 && addr_q[1:0] != 2'b00) ||
                  (is_half && addr_q[0]) || addr_q[31:2] >= 30'(DEPTH_WORDS);
        old     = mem[addr_q[AW+1:2]];
        half_v  = addr_q[1] ? old[31:16] : old[15:0];
        byte_v  = old[{addr_q[1:0], 3'b000} +: 8];
        load    = op_q == 3'd0 ? old :
                  op_q == 3'd1 ? {16'h0, half_v} :
                  op_q == 3'd2 ? {{16{half_v[15]}}, half_v} :
                  op_q == 3'd3 ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
        lanes   = op_q == 3'd0 ? 4'hf : is_half ? (addr_q[1] ? 4'hc : 4'h3) : 4'b0001 << addr_q[1:0];
        aligned = is_half ? {2{wdata_q[15:0]}} : is_byte ? {4{wdata_q[7:0]}} : wdata_q;
        mask    = {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
        merged  = (aligned & mask) | (old & ~mask);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= 8'd0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
            we_q       <= 1'b0;
            op_q       <= 3'd0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            pc_q       <= 32'h0;
            for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'h0;
        end else if (state == IDLE && req_valid) begin
            cnt     <= 8'(LATENCY - 1);
            we_q    <= req_we;
            op_q    <= req_op;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            pc_q    <= req_pc;
        end else if (state == BUSY) begin
            if (cnt != 8'd0) begin
                cnt <= cnt - 8'd1;
            end else begin
                resp_rdata <= (err || we_q) ? 32'h0 : load;
                resp_err   <= err;
                if (we_q && !err) begin
                    mem[addr_q[AW+1:2]] <= merged;
                    $display("@%h: *%h <= %h", pc_q, {addr_q[31:2], 2'b00}, merged);
                end
            end
        end
    end
endmodule

// File: tb/tb_dm_multicycle.sv
// tb_dm_multicycle: directed scoreboard bench for dm_multicycle with LATENCY=2.
module tb_dm_multicycle;
    logic        clk = 1'b0, reset = 1'b1, req_valid = 1'b0, req_we = 1'b0;
    logic        req_ready, resp_valid, resp_err;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0, req_pc = 32'h0, resp_rdata;
    logic [32:0] q[$];
    int          total = 0, bad = 0;
    logic [31:0] pc_ctr = 32'h0040_0000;
    time         acc_t, prev_t;

    dm_multicycle #(.DEPTH_WORDS(3072), .LATENCY(2)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_pc(req_pc), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every response must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!reset && resp_valid) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp: got rdata=%h err=%b want none", resp_rdata, resp_err);
            end else begin
                logic [32:0] e;
                e = q.pop_front();
                chk("resp_rdata", resp_rdata, e[31:0]);
                chk("resp_err", {31'h0, resp_err}, {31'h0, e[32]});
            end
        end
    end

    task automatic send(input logic we, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [32:0] exp, input bit push);
        int n = 0;
        @(negedge clk);
        req_we = we; req_op = op; req_addr = addr; req_wdata = wdata;
        req_pc = pc_ctr; pc_ctr += 32'd4; req_valid = 1'b1;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got no ready want ready");
        end
        if (push) q.push_back(exp);
        @(posedge clk);
        acc_t = $time;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'h0, req_ready}, 32'd1);
        chk("rst_valid", {31'h0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_err", {31'h0, resp_err}, 32'd0);
        reset = 1'b0;

        send(1, 3'd0, 32'h10, 32'h12345678, 33'h0, 1);
        #1 req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("busy_ready_low", {31'h0, req_ready}, 32'd0);
            chk("resp_timing", {31'h0, resp_valid}, i == 2 ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        chk("ready_back", {31'h0, req_ready}, 32'd1);

        send(0, 3'd0, 32'h10, 32'h0, {1'b0, 32'h12345678}, 1);
        send(1, 3'd3, 32'h11, 32'h000000AB, 33'h0, 1);
        send(0, 3'd0, 32'h10, 32'h0, {1'b0, 32'h1234AB78}, 1);
        send(0, 3'd4, 32'h11, 32'h0, {1'b0, 32'hFFFFFFAB}, 1);
        send(0, 3'd3, 32'h11, 32'h0, {1'b0, 32'h000000AB}, 1);
        send(1, 3'd1, 32'h12, 32'h0000BEEF, 33'h0, 1);
        send(0, 3'd0, 32'h10, 32'h0, {1'b0, 32'hBEEFAB78}, 1);
        send(0, 3'd2, 32'h12, 32'h0, {1'b0, 32'hFFFFBEEF}, 1);
        send(0, 3'd1, 32'h12, 32'h0, {1'b0, 32'h0000BEEF}, 1);
        send(0, 3'd3, 32'h13, 32'h0, {1'b0, 32'h000000BE}, 1);
        send(0, 3'd4, 32'h10, 32'h0, {1'b0, 32'h00000078}, 1);

        send(0, 3'd0, 32'h13, 32'h0, {1'b1, 32'h0}, 1);
        send(1, 3'd1, 32'h11, 32'h00001111, {1'b1, 32'h0}, 1);
        send(1, 3'd0, 32'h3000, 32'h55555555, {1'b1, 32'h0}, 1);
        send(0, 3'd5, 32'h10, 32'h0, {1'b1, 32'h0}, 1);
        send(1, 3'd7, 32'h10, 32'h66666666, {1'b1, 32'h0}, 1);
        send(0, 3'd0, 32'h10, 32'h0, {1'b0, 32'hBEEFAB78}, 1);
        send(1, 3'd0, 32'h2FFC, 32'hCAFEF00D, 33'h0, 1);
        send(0, 3'd0, 32'h2FFC, 32'h0, {1'b0, 32'hCAFEF00D}, 1);

        // req_valid stays high across these; accepts must be exactly 4 cycles apart
        send(1, 3'd0, 32'h40, 32'h11111111, 33'h0, 1);
        prev_t = acc_t;
        send(0, 3'd0, 32'h40, 32'h0, {1'b0, 32'h11111111}, 1);
        chk("interval1", 32'(acc_t - prev_t), 32'd40);
        prev_t = acc_t;
        send(1, 3'd4, 32'h45, 32'h00000080, 33'h0, 1);
        chk("interval2", 32'(acc_t - prev_t), 32'd40);
        prev_t = acc_t;
        send(0, 3'd0, 32'h44, 32'h0, {1'b0, 32'h00008000}, 1);
        chk("interval3", 32'(acc_t - prev_t), 32'd40);
        #1 req_valid = 1'b0;
        repeat (6) @(negedge clk);

        send(1, 3'd0, 32'h20, 32'hDEADBEEF, 33'h0, 0);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("post_rst_ready", {31'h0, req_ready}, 32'd1);
        chk("post_rst_valid", {31'h0, resp_valid}, 32'd0);
        repeat (4) begin
            @(negedge clk);
            chk("no_resp_after_rst", {31'h0, resp_valid}, 32'd0);
        end
        send(0, 3'd0, 32'h20, 32'h0, {1'b0, 32'h0}, 1);
        send(0, 3'd0, 32'h10, 32'h0, {1'b0, 32'h0}, 1);
        #1 req_valid = 1'b0;

        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
